// File: rtl/matrix_loader.sv
// ---------------------------------------------------------------------------
// matrix_loader
//
// Write-side front end for the determinant datapath. It takes matrix elements
// one per cycle in row-major order and packs them into a 4x4 matrix word.
// An NxN matrix (N = 2, 3 or 4) sits in the top-left corner of that word.
// The completed word is then presented on an out_valid/out_ready handshake.
//
// Parameters
//   ELEM_W        element width in bits; matrix is 16*ELEM_W bits wide
//   PAD_IDENTITY  1: unused diagonal slots are set to 1 so that the padded
//                    determinant equals the NxN determinant
//                 0: every unused slot is 0
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous abort back to IDLE; an element offered in the
//                   same cycle is dropped
//   size       in   [2:0] matrix dimension N, sampled on the first element
//   in_data    in   [ELEM_W-1:0] signed element, row-major order
//   in_valid   in   element present
//   in_last    in   final element of the frame
//   in_ready   out  element accepted this cycle (low only while holding)
//   matrix     out  [16*ELEM_W-1:0] element (r,c) at [W-1-ELEM_W*(4r+c) -: ELEM_W]
//   out_valid  out  matrix complete and stable
//   out_ready  in   consumer takes the matrix
//   frame_err  out  one-cycle pulse on a framing or size error
// ---------------------------------------------------------------------------
module matrix_loader #(
    parameter int ELEM_W       = 8,
    parameter int PAD_IDENTITY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic [2:0]               size,
    input  logic signed [ELEM_W-1:0] in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [16*ELEM_W-1:0]     matrix,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     frame_err
);

    localparam int W = 16 * ELEM_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     n_q, n_d;
    logic [3:0]     count_q, count_d;
    logic [1:0]     row_q, row_d;
    logic [1:0]     col_q, col_d;
    logic [W-1:0]   matrix_q, matrix_d;
    logic           frame_err_q, frame_err_d;
    logic           accept;
    logic           size_ok;

    // Zero matrix, optionally with 1s on the diagonal slots that the NxN
    // matrix does not cover.
    function automatic logic [W-1:0] pad_matrix(input logic [2:0] n);
        logic [W-1:0] res;
        res = '0;
        for (int k = 0; k < 4; k++) begin
            if ((PAD_IDENTITY != 0) && (3'(k) >= n)) begin
                res[W-1-ELEM_W*(5*k) -: ELEM_W] = ELEM_W'(1);
            end
        end
        return res;
    endfunction

    // Replace element (r,c) of a packed matrix.
    function automatic logic [W-1:0] put_elem(input logic [W-1:0]      m,
                                               input logic [1:0]        r,
                                               input logic [1:0]        c,
                                               input logic [ELEM_W-1:0] v);
        logic [W-1:0] res;
        res = m;
        for (int k = 0; k < 16; k++) begin
            if (4'(k) == {r, c}) begin
                res[W-1-ELEM_W*k -: ELEM_W] = v;
            end
        end
        return res;
    endfunction

    // Index of the final slot, N*N-1.
    function automatic logic [3:0] last_slot(input logic [2:0] n);
        logic [3:0] res;
        case (n)
            3'd2:    res = 4'd3;
            3'd3:    res = 4'd8;
            default: res = 4'd15;
        endcase
        return res;
    endfunction

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign matrix    = matrix_q;
    assign frame_err = frame_err_q;

    // clear wins over any element offered in the same cycle.
    assign accept  = in_valid && in_ready && !clear;
    assign size_ok = (size == 3'd2) || (size == 3'd3) || (size == 3'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            n_q         <= 3'd0;
            count_q     <= 4'd0;
            row_q       <= 2'd0;
            col_q       <= 2'd0;
            matrix_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            count_q     <= count_d;
            row_q       <= row_d;
            col_q       <= col_d;
            matrix_q    <= matrix_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        count_d     = count_q;
        row_d       = row_q;
        col_d       = col_q;
        matrix_d    = matrix_q;
        frame_err_d = 1'b0;

        if (clear) begin
            state_d  = IDLE;
            count_d  = 4'd0;
            row_d    = 2'd0;
            col_d    = 2'd0;
            matrix_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        n_d = size;
                        if (in_last) begin
                            // A one-element frame is never valid, whatever the size.
                            frame_err_d = 1'b1;
                        end else if (size_ok) begin
                            matrix_d = put_elem(pad_matrix(size), 2'd0, 2'd0, in_data);
                            count_d  = 4'd1;
                            row_d    = 2'd0;
                            col_d    = 2'd1;
                            state_d  = LOAD;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end

                LOAD: begin
                    if (accept) begin
                        matrix_d = put_elem(matrix_q, row_q, col_q, in_data);
                        if (count_q == last_slot(n_q)) begin
                            // A missing in_last is flagged, but the matrix is still delivered.
                            frame_err_d = !in_last;
                            state_d     = HOLD;
                        end else if (in_last) begin
                            frame_err_d = 1'b1;
                            matrix_d    = '0;
                            count_d     = 4'd0;
                            row_d       = 2'd0;
                            col_d       = 2'd0;
                            state_d     = IDLE;
                        end else begin
                            count_d = count_q + 4'd1;
                            if ({1'b0, col_q} == (n_q - 3'd1)) begin
                                col_d = 2'd0;
                                row_d = row_q + 2'd1;
                            end else begin
                                col_d = col_q + 2'd1;
                            end
                        end
                    end
                end

                DRAIN: begin
                    if (accept && in_last) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end

                HOLD: begin
                    // matrix stays as delivered until the next frame starts.
                    if (out_ready) begin
                        count_d = 4'd0;
                        row_d   = 2'd0;
                        col_d   = 2'd0;
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
module tb_matrix_loader;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic [2:0]   size;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         out_ready;

    logic         in_ready, out_valid, frame_err;
    logic [127:0] matrix;
    logic         in_ready_z, out_valid_z, frame_err_z;
    logic [127:0] matrix_z;

    int total  = 0;
    int passed = 0;

    matrix_loader #(.ELEM_W(8), .PAD_IDENTITY(1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .size(size),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .matrix(matrix), .out_valid(out_valid),
        .out_ready(out_ready), .frame_err(frame_err)
    );

    matrix_loader #(.ELEM_W(8), .PAD_IDENTITY(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .clear(clear), .size(size),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_z), .matrix(matrix_z), .out_valid(out_valid_z),
        .out_ready(out_ready), .frame_err(frame_err_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send n elements base, base+1, ...; in_last on element last_at (-1 = none).
    task automatic send(input logic [2:0] sz, input int n, input logic [7:0] base, input int last_at);
        for (int i = 0; i < n; i++) begin
            size     = sz;
            in_data  = base + 8'(i);
            in_last  = (i == last_at);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_matrix();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; size = 3'd0; in_data = 8'd0;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        #2;
        check("rst_matrix", matrix, 128'd0);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_frame_err", {127'd0, frame_err}, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // 4x4 frame 1..16
        send(3'd4, 15, 8'd1, -1);
        check("4x4_not_yet_valid", {127'd0, out_valid}, 128'd0);
        send(3'd4, 1, 8'd16, 0);
        check("4x4_out_valid", {127'd0, out_valid}, 128'd1);
        check("4x4_matrix", matrix, 128'h0102030405060708090A0B0C0D0E0F10);
        check("4x4_frame_err", {127'd0, frame_err}, 128'd0);

        // consumer stalls for 10 cycles
        for (int i = 0; i < 10; i++) begin
            check("hold_out_valid", {127'd0, out_valid}, 128'd1);
            check("hold_in_ready", {127'd0, in_ready}, 128'd0);
            tick();
        end
        check("hold_matrix", matrix, 128'h0102030405060708090A0B0C0D0E0F10);
        release_matrix();
        check("rel_out_valid", {127'd0, out_valid}, 128'd0);
        check("rel_in_ready", {127'd0, in_ready}, 128'd1);
        check("rel_matrix_kept", matrix, 128'h0102030405060708090A0B0C0D0E0F10);

        // 2x2 {3,4,5,6} in both padding modes
        send(3'd2, 4, 8'd3, 3);
        check("2x2_ident", matrix, 128'h03040000_05060000_00000100_00000001);
        check("2x2_zero", matrix_z, 128'h03040000_05060000_00000000_00000000);
        check("2x2_valid_both", {126'd0, out_valid, out_valid_z}, 128'd3);
        check("2x2_err_both", {126'd0, frame_err, frame_err_z}, 128'd0);
        release_matrix();
        check("2x2_ready_z", {127'd0, in_ready_z}, 128'd1);

        // single element frame with a valid size: error, matrix untouched
        send(3'd3, 1, 8'h55, 0);
        check("one_elem_err", {127'd0, frame_err}, 128'd1);
        check("one_elem_matrix", matrix, 128'h03040000_05060000_00000100_00000001);
        check("one_elem_idle", {126'd0, out_valid, in_ready}, 128'd1);

        // 3x3 ending early on the 5th element
        send(3'd3, 5, 8'h11, 4);
        check("early_err", {127'd0, frame_err}, 128'd1);
        check("early_matrix", matrix, 128'd0);
        check("early_out_valid", {127'd0, out_valid}, 128'd0);
        tick();
        check("early_err_pulse", {127'd0, frame_err}, 128'd0);
        send(3'd3, 9, 8'd1, 8);
        check("3x3_matrix", matrix, 128'h01020300_04050600_07080900_00000001);
        check("3x3_valid", {127'd0, out_valid}, 128'd1);
        check("3x3_err", {127'd0, frame_err}, 128'd0);
        release_matrix();

        // 2x2 without in_last: delivered but flagged
        send(3'd2, 4, 8'd7, -1);
        check("nolast_err", {127'd0, frame_err}, 128'd1);
        check("nolast_valid", {127'd0, out_valid}, 128'd1);
        check("nolast_matrix", matrix, 128'h07080000_090A0000_00000100_00000001);
        release_matrix();

        // size 5: drained, one error pulse, no output
        send(3'd5, 3, 8'h20, -1);
        check("bad_size_no_err", {127'd0, frame_err}, 128'd0);
        check("bad_size_no_valid", {127'd0, out_valid}, 128'd0);
        send(3'd5, 1, 8'h23, 0);
        check("bad_size_err", {127'd0, frame_err}, 128'd1);
        check("bad_size_no_valid2", {127'd0, out_valid}, 128'd0);
        tick();
        check("bad_size_err_pulse", {127'd0, frame_err}, 128'd0);
        send(3'd4, 16, 8'h80, 15);
        check("neg_4x4_matrix", matrix, 128'h808182838485868788898A8B8C8D8E8F);
        check("neg_4x4_valid", {127'd0, out_valid}, 128'd1);
        release_matrix();

        // clear after 7 elements; element offered with clear is dropped
        send(3'd4, 7, 8'h40, -1);
        clear = 1'b1; in_valid = 1'b1; in_data = 8'h99; size = 3'd2;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clear_matrix", matrix, 128'd0);
        check("clear_out_valid", {127'd0, out_valid}, 128'd0);
        check("clear_in_ready", {127'd0, in_ready}, 128'd1);
        check("clear_err", {127'd0, frame_err}, 128'd0);
        send(3'd2, 4, 8'd3, 3);
        check("post_clear_matrix", matrix, 128'h03040000_05060000_00000100_00000001);
        check("post_clear_valid", {127'd0, out_valid}, 128'd1);

        // asynchronous reset while holding
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {127'd0, out_valid}, 128'd0);
        check("async_rst_matrix", matrix, 128'd0);
        check("async_rst_ready", {127'd0, in_ready}, 128'd1);
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
- Write-side front end for the determinant datapath. Accepts matrix elements one per cycle from the HPS-side element stream, in row-major order, with valid/ready/last framing.
- Packs the elements into the 128-bit 4x4 matrix word consumed by the determinant units and presents it with an out_valid/out_ready handshake.
- Matrices of size N = 2, 3 or 4 are placed in the top-left corner of the 4x4 grid. Unused positions are zero- or identity-padded.

Parameters:
ELEM_W, 8, element width in bits; matrix output width is 16*ELEM_W.
PAD_IDENTITY, 1, 1: unused diagonal positions = 1, so the padded 4x4 determinant equals the NxN determinant; 0: all unused positions = 0.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
clear  input  1  synchronous abort; highest priority after reset.
size  input  3  matrix dimension N; valid values 2, 3, 4; sampled on the first element of a frame.
in_data  input  ELEM_W  signed element, row-major.
in_valid  input  1  element present.
in_last  input  1  marks the final element of a frame.
in_ready  output  1  loader accepts the element this cycle.
matrix  output  16*ELEM_W  packed matrix; element (r,c) at bits [W-1-ELEM_W*(4r+c) -: ELEM_W], with W = 16*ELEM_W.
out_valid  output  1  matrix complete and stable.
out_ready  input  1  consumer takes the matrix.
frame_err  output  1  one-cycle pulse on a framing or size error.

Behaviour:
- Reset values: matrix = 0, out_valid = 0, frame_err = 0, state = IDLE, count = 0, in_ready = 1.
- Accept: an element is accepted when in_valid && in_ready.
- in_ready is decoded from state: 1 in IDLE, LOAD and DRAIN; 0 in HOLD.
- State IDLE, first element accepted:
  - Latch N = size.
  - If N is 2..4: matrix <= pad(N) with element (0,0) written, count <= 1, go to LOAD.
  - If N is 0, 1 or 5-7: go to DRAIN. If in_last is also asserted, instead pulse frame_err and stay in IDLE.
  - Special case N valid but in_last also asserted on this element: pulse frame_err, stay in IDLE, matrix unchanged.
- Padding pad(N): all zeros. If PAD_IDENTITY = 1, additionally (k,k) = 1 for k = N..3.
- State LOAD, element accepted:
  - Write it to (count/N, count%N); count increments.
  - Element with count == N*N-1 (the last slot): go to HOLD next cycle. If in_last = 0 on that element, pulse frame_err; the matrix is still delivered.
  - in_last on an element with count < N*N-1: early end. Pulse frame_err, discard the partial matrix (matrix <= 0), return to IDLE.
- State DRAIN: accept and discard elements until in_last is accepted, then pulse frame_err and return to IDLE.
- State HOLD:
  - out_valid = 1; matrix is held stable.
  - out_valid && out_ready: out_valid <= 0, go to IDLE next cycle. matrix keeps its value until the next frame starts.
  - No element is accepted in HOLD, so there is a one-cycle bubble between back-to-back frames.
- Latency: out_valid rises on the first clock edge after the final element is accepted.
- clear: in any state, next cycle state = IDLE, count = 0, out_valid = 0, matrix = 0. Any element presented in the same cycle is dropped, even though in_ready may read 1.
- Reset mid-frame: all state returns immediately to the reset values; the partial frame is lost.
- Counter: 4 bits; never wraps, because the transition to HOLD occurs at count == N*N-1.
- frame_err: registered, high for exactly one cycle per error event.
- Element values pass through bit-exact; no arithmetic is performed.

Test Plan:
- 4x4 frame, elements 1..16 (hex 01..10), in_last on the 16th -> out_valid one cycle later with matrix = 128'h0102030405060708090A0B0C0D0E0F10 and frame_err = 0.
- 2x2 frame {3,4,5,6}: with PAD_IDENTITY = 1 -> matrix = 128'h03040000_05060000_00000100_00000001; with PAD_IDENTITY = 0 -> 128'h03040000_05060000_00000000_00000000.
- 3x3 frame with in_last on the 5th element -> frame_err pulses one cycle, matrix = 0, out_valid stays 0; a following valid 3x3 frame loads correctly.
- out_ready held low for 10 cycles after completion -> out_valid and matrix stay stable and in_ready = 0; out_ready = 1 for one cycle -> out_valid drops and in_ready = 1 on the next cycle.
- size = 5 with 4 elements, last on the 4th -> frame_err pulses once after the 4th element, out_valid never asserts; then size = 4 with 16 elements -> normal completion.
- clear asserted after 7 elements of a 4x4 frame -> next cycle IDLE, matrix = 0; rst_n pulsed low during HOLD -> out_valid = 0 immediately, asynchronously.
